// File: rtl/hw3proc_key_in.sv
// hw3proc_key_in: debounced key/switch input port with edge capture and IRQ on an Avalon-MM slave
module hw3proc_key_in #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit FALLING = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [WIDTH-1:0] sync1, sync2, deb, deb_nxt, done, edge_det, edgecap, irqmask, clr;
  logic wr;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      logic [CW-1:0] cnt;
      assign done[i] = (sync2[i] != deb[i]) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else cnt <= (sync2[i] == deb[i] || done[i]) ? '0 : cnt + CW'(1);
    end
  endgenerate
  assign deb_nxt = (deb & ~done) | (sync2 & done);
  // Capture on the same edge the debounced level changes
  assign edge_det = FALLING ? (deb & ~deb_nxt) : (~deb & deb_nxt);
  assign wr = chipselect & ~write_n;
  assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
      deb <= '1;
      edgecap <= '0;
      irqmask <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      deb <= deb_nxt;
      edgecap <= (edgecap & ~clr) | edge_det;
      if (wr && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
    end
  always_comb
    readdata = address == 2'd0 ? 32'(deb) :
               address == 2'd2 ? 32'(irqmask) :
               address == 2'd3 ? 32'(edgecap) : 32'd0;
  assign irq = |(edgecap & irqmask);
endmodule

// File: tb/tb_hw3proc_key_in.sv
// tb_hw3proc_key_in: directed checks of debounce latency, glitch rejection, edge capture, IRQ and register map
module tb_hw3proc_key_in;
  logic clk = 0, reset_n = 0;
  logic [1:0] address = 0;
  logic chipselect = 0, write_n = 1;
  logic [31:0] writedata = 0;
  logic [3:0] in_port = 4'hF;
  logic [31:0] readdata;
  logic irq;
  int checks = 0, errors = 0;

  hw3proc_key_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .FALLING(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask

  task automatic test_reset;
    reset_n = 0; in_port = 4'hF;
    cycles(2);
    rd(0); checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL reset_data got %h exp %h", readdata, 32'hF); end
    rd(2); checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp %h", readdata, 32'h0); end
    rd(3); checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_edge got %h exp %h", readdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    reset_n = 1;
    cycles(3);
  endtask

  task automatic test_glitch;
    in_port = 4'hD;
    cycles(3);
    in_port = 4'hF;
    cycles(8);
    rd(0); checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL glitch_data got %h exp %h", readdata, 32'hF); end
    rd(3); checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL glitch_edge got %h exp %h", readdata, 32'h0); end
  endtask

  task automatic test_step;
    rd(0);
    in_port = 4'hE;
    cycles(5);
    #1; checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL step_early got %h exp %h", readdata, 32'hF); end
    cycles(1);
    #1; checks++; if (readdata !== 32'hE) begin errors++; $display("FAIL step_data got %h exp %h", readdata, 32'hE); end
    rd(3); checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL step_edge got %h exp %h", readdata, 32'h1); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL step_irq_masked got %b exp 0", irq); end
  endtask

  task automatic test_irq;
    wr(2, 32'h1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
    rd(2); checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL irq_mask got %h exp %h", readdata, 32'h1); end
    wr(3, 32'h1);
    rd(3); checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL irq_clr_edge got %h exp %h", readdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", irq); end
  endtask

  task automatic test_collision;
    in_port = 4'hA;
    cycles(5);
    wr(3, 32'h4);
    rd(0); checks++; if (readdata !== 32'hA) begin errors++; $display("FAIL coll_data got %h exp %h", readdata, 32'hA); end
    rd(3); checks++; if (readdata !== 32'h4) begin errors++; $display("FAIL coll_edge got %h exp %h", readdata, 32'h4); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL coll_irq got %b exp 0", irq); end
  endtask

  task automatic test_regmap;
    wr(0, 32'hFFFF_FFFF);
    wr(1, 32'hFFFF_FFFF);
    rd(0); checks++; if (readdata !== 32'hA) begin errors++; $display("FAIL map_a0 got %h exp %h", readdata, 32'hA); end
    rd(1); checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL map_a1 got %h exp %h", readdata, 32'h0); end
    rd(2); checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL map_a2 got %h exp %h", readdata, 32'h1); end
    rd(3); checks++; if (readdata !== 32'h4) begin errors++; $display("FAIL map_a3 got %h exp %h", readdata, 32'h4); end
    wr(2, 32'hFFFF_FFFF);
    rd(2); checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL map_mask_upper got %h exp %h", readdata, 32'hF); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL map_irq got %b exp 1", irq); end
  endtask

  task automatic test_reset_mid;
    in_port = 4'hF;
    cycles(8);
    rd(0); checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL mid_pre_data got %h exp %h", readdata, 32'hF); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_pre_irq got %b exp 1", irq); end
    in_port = 4'hE;
    cycles(4);
    reset_n = 0;
    #1; checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq got %b exp 0", irq); end
    rd(2); checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL mid_rst_mask got %h exp %h", readdata, 32'h0); end
    rd(3); checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL mid_rst_edge got %h exp %h", readdata, 32'h0); end
    rd(0); checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL mid_rst_data got %h exp %h", readdata, 32'hF); end
    cycles(2);
    reset_n = 1;
    cycles(5);
    #1; checks++; if (readdata !== 32'hF) begin errors++; $display("FAIL mid_early got %h exp %h", readdata, 32'hF); end
    cycles(1);
    #1; checks++; if (readdata !== 32'hE) begin errors++; $display("FAIL mid_data got %h exp %h", readdata, 32'hE); end
    rd(3); checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL mid_edge got %h exp %h", readdata, 32'h1); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_glitch;
    test_step;
    test_irq;
    test_collision;
    test_regmap;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
